// File: rtl/serial_frame_scheduler_pkg.sv
// Shared types and constants for the serial frame scheduler.
package serial_frame_scheduler_pkg;
  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/serial_frame_scheduler_if.sv
// Requester and detector-facing signals of the serial frame scheduler.
interface serial_frame_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2,
  parameter int CNT_W  = 4
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic [N_REQ-1:0]        grant;
  logic                    busy;
  logic                    x_out;
  logic                    det_rst_n;
  logic                    y_in;
  logic                    done;
  logic [ID_W-1:0]         done_id;
  logic [CNT_W-1:0]        hit_count;

  modport master (output req, data_in, y_in,
                  input  grant, busy, x_out, det_rst_n, done, done_id, hit_count);
  modport slave  (input  req, data_in, y_in,
                  output grant, busy, x_out, det_rst_n, done, done_id, hit_count);
endinterface

// File: rtl/serial_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            vld
);
  // Walk offsets from far to near so the closest requester wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int o = N - 1; o >= 0; o--) begin
      if (req[(int'(ptr) + o) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + o) % N] = 1'b1;
        idx = ID_W'((int'(ptr) + o) % N);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/serial_frame_scheduler.sv
// Round-robin frame scheduler feeding one shared serial sequence detector.
module serial_frame_scheduler
  import serial_frame_scheduler_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAG    = 0,
  parameter int ID_W   = clog2(N_REQ),
  parameter int CNT_W  = clog2(DATA_W + 1)
) (
  input logic                    clock,
  input logic                    reset,
  serial_frame_scheduler_if.slave bus
);
  localparam int PW = clog2(DATA_W + LAG + 1);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, cur_id, arb_idx;
  logic [N_REQ-1:0]  arb_gnt;
  logic              arb_vld;
  logic [DATA_W-1:0] shift_reg;
  logic [PW-1:0]     bit_cnt;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_en;

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .req (bus.req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  // Grant is suppressed while reset is low so no frame looks accepted then.
  assign bus.grant = (state == IDLE && reset) ? arb_gnt : '0;

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    case (state)
      IDLE:   if (arb_vld) state_nxt = CLEAR;
      CLEAR:  state_nxt = SHIFT;
      SHIFT:  if (bit_cnt == PW'(DATA_W - 1)) state_nxt = (LAG > 0) ? DRAIN : REPORT;
      DRAIN:  if (bit_cnt == PW'(DATA_W + LAG - 1)) state_nxt = REPORT;
      REPORT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Window skips the first LAG shift cycles and adds LAG drain cycles.
    if (((state == SHIFT && ({1'b0, bit_cnt} + 1'b1) > (PW + 1)'(LAG)) || state == DRAIN)
        && bus.y_in && cnt != CNT_W'(DATA_W))
      cnt_en = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cur_id        <= '0;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.x_out     <= 1'b0;
      bus.det_rst_n <= 1'b0;
      bus.done      <= 1'b0;
      bus.done_id   <= '0;
      bus.hit_count <= '0;
    end else begin
      state         <= state_nxt;
      bus.busy      <= (state_nxt != IDLE);
      bus.det_rst_n <= (state_nxt == SHIFT || state_nxt == DRAIN);
      bus.done      <= (state_nxt == REPORT);
      bus.x_out     <= 1'b0;
      case (state)
        IDLE: if (arb_vld) begin
          shift_reg <= bus.data_in[int'(arb_idx)*DATA_W +: DATA_W];
          cur_id    <= arb_idx;
          rr_ptr    <= (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
        end
        CLEAR: begin
          cnt       <= '0;
          bit_cnt   <= '0;
          bus.x_out <= shift_reg[DATA_W-1];
          shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
        end
        SHIFT, DRAIN: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (cnt_en) cnt <= cnt + 1'b1;
          if (state_nxt == SHIFT) begin
            bus.x_out <= shift_reg[DATA_W-1];
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
      // Result registers load on entry to REPORT and hold until the next one.
      if (state_nxt == REPORT) begin
        bus.done_id   <= cur_id;
        bus.hit_count <= cnt + CNT_W'(cnt_en);
      end
    end
  end
endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Random + directed bench: Mealy (LAG=0) and Moore (LAG=1) schedulers vs a timeline model.
module tb_serial_frame_scheduler;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  rq [2];
  logic [31:0] dt [2];
  logic [2:0]  h0, h1;
  int n_vec = 0, n_err = 0;

  int         ph[2], rr[2], cid[2], lid[2], lhit[2], gr[2];
  logic [7:0] cdat[2];
  bit         hold[2];
  int         lag[2] = '{0, 1};

  always #5 clock = ~clock;

  serial_frame_scheduler_if #(.N_REQ(4), .DATA_W(8), .ID_W(2), .CNT_W(4)) i0 ();
  serial_frame_scheduler_if #(.N_REQ(4), .DATA_W(8), .ID_W(2), .CNT_W(4)) i1 ();

  serial_frame_scheduler #(.N_REQ(4), .DATA_W(8), .LAG(0), .ID_W(2), .CNT_W(4)) dut0 (
    .clock(clock), .reset(reset), .bus(i0.slave));
  serial_frame_scheduler #(.N_REQ(4), .DATA_W(8), .LAG(1), .ID_W(2), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .bus(i1.slave));

  assign i0.req = rq[0];
  assign i1.req = rq[1];
  assign i0.data_in = dt[0];
  assign i1.data_in = dt[1];

  // Detectors for "111", overlapping: Mealy on dut0, Moore on dut1.
  always_ff @(posedge clock) begin
    h0 <= i0.det_rst_n ? {h0[1:0], i0.x_out} : 3'b000;
    h1 <= i1.det_rst_n ? {h1[1:0], i1.x_out} : 3'b000;
  end
  assign i0.y_in = i0.x_out & h0[0] & h0[1];
  assign i1.y_in = h1[0] & h1[1] & h1[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int o = 0; o < 4; o++) if (r[(p + o) % 4]) return (p + o) % 4;
    return -1;
  endfunction

  // Serial bit k is w[7-k]; a hit is any three consecutive ones ending at k.
  function automatic int hits(input logic [7:0] w);
    int n = 0;
    for (int k = 2; k < 8; k++) if (w[7-k] && w[8-k] && w[9-k]) n++;
    return n;
  endfunction

  // ph = cycle offset from the grant cycle; -1 means idle.
  task automatic model(input int d, input logic [3:0] gnt, input logic bsy, input logic xo,
                       input logic drn, input logic dn, input logic [1:0] did, input logic [3:0] hc);
    int g = -1;
    int f = 8 + lag[d] + 3;
    if (ph[d] < 0 && reset) begin
      g = pick(rq[d], rr[d]);
      if (g >= 0) begin
        ph[d] = 0; cid[d] = g; cdat[d] = dt[d][g*8 +: 8]; rr[d] = (g + 1) % 4;
      end
    end
    gr[d] = g;
    chk($sformatf("d%0d.grant", d), 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk($sformatf("d%0d.busy", d), 32'(bsy), 32'(ph[d] >= 1));
    chk($sformatf("d%0d.x_out", d), 32'(xo),
        (ph[d] >= 2 && ph[d] <= 9) ? 32'(cdat[d][9 - ph[d]]) : 32'd0);
    chk($sformatf("d%0d.det_rst_n", d), 32'(drn), 32'(ph[d] >= 2 && ph[d] <= 9 + lag[d]));
    chk($sformatf("d%0d.done", d), 32'(dn), 32'(ph[d] == f - 1));
    if (ph[d] == f - 1) begin
      lid[d] = cid[d]; lhit[d] = hits(cdat[d]);
    end
    chk($sformatf("d%0d.done_id", d), 32'(did), 32'(lid[d]));
    chk($sformatf("d%0d.hit_count", d), 32'(hc), 32'(lhit[d]));
    if (ph[d] >= 0) ph[d] = (ph[d] + 1 == f) ? -1 : ph[d] + 1;
    if (!reset) begin
      ph[d] = -1; rr[d] = 0; lid[d] = 0; lhit[d] = 0;
    end
  endtask

  task automatic step();
    @(negedge clock);
    model(0, i0.grant, i0.busy, i0.x_out, i0.det_rst_n, i0.done, i0.done_id, i0.hit_count);
    model(1, i1.grant, i1.busy, i1.x_out, i1.det_rst_n, i1.done, i1.done_id, i1.hit_count);
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) if (gr[d] >= 0 && !hold[d]) rq[d][gr[d]] = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_grant(input int d, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (gr[d] >= 0) return;
    end
    chk($sformatf("d%0d.wait_grant", d), 32'(gr[d] >= 0), 32'd1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ph[d] = -1; rr[d] = 0; cid[d] = 0; lid[d] = 0; lhit[d] = 0; gr[d] = -1;
      cdat[d] = '0; hold[d] = 1'b0; rq[d] = '0; dt[d] = '0;
    end
    repeat (2) @(posedge clock);
    #1;
    step();
    reset = 1'b1;
    run(2);

    // Single request, mixed pattern: 3 hits on both detector flavours.
    rq[0] = 4'b0001; dt[0][7:0] = 8'hF7;
    rq[1] = 4'b0001; dt[1][7:0] = 8'hF7;
    run(16);

    // All requesters held with all-ones frames: strict rotation, 6 hits each.
    hold[0] = 1'b1; hold[1] = 1'b1;
    rq[0] = 4'hF; rq[1] = 4'hF; dt[0] = '1; dt[1] = '1;
    run(60);
    hold[0] = 1'b0; hold[1] = 1'b0;
    rq[0] = '0; rq[1] = '0;
    run(15);

    // Wrap and skip after a grant to id 2.
    rq[0] = 4'b0100;
    wait_grant(0, 40);
    rq[0] = 4'b0011;
    run(30);

    // Back-to-back frames 03 then 80 on one requester: detector must not carry over.
    rq[0] = 4'b0001; dt[0][7:0] = 8'h03;
    wait_grant(0, 40);
    rq[0] = 4'b0001; dt[0][7:0] = 8'h80;
    run(30);

    // Reset at bit 4 of a frame; re-request 0 and 3 so rr_ptr restart is visible.
    rq[0] = 4'b0001; rq[1] = 4'b0001;
    wait_grant(0, 40);
    rq[0] = 4'b1001; rq[1] = 4'b1001;
    run(5);
    reset = 1'b0;
    step();
    reset = 1'b1;
    run(30);

    // Random traffic, drops before grant, data churn and occasional reset.
    for (int c = 0; c < 2500; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          if (!rq[d][i]) begin
            if ($urandom_range(0, 5) == 0) rq[d][i] = 1'b1;
          end else if ($urandom_range(0, 30) == 0) rq[d][i] = 1'b0;
          dt[d][i*8 +: 8] = 8'($urandom | $urandom);
        end
      end
      reset = ($urandom_range(0, 400) != 0);
      step();
    end
    reset = 1'b1;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
